// File: rtl/mac_tx_framer.sv
// mac_tx_framer
//   Ethernet transmit framer feeding the PHY preamble/gap stage. Takes a frame
//   byte stream (dest MAC through payload) over valid/ready. It can zero-pad
//   short frames to MIN_FRAME bytes. It appends the IEEE 802.3 CRC32 FCS. It
//   holds off the next frame until the PHY stage drops phy_active.
//
//   Build option: define MAC_TX_FRAMER_PAD_EN to enable zero padding up to
//   MIN_FRAME bytes. With it undefined the frame goes straight from the last
//   payload byte to the FCS and MIN_FRAME has no effect.
//
// Ports
//   clock, reset      single clock, synchronous active-high reset
//   in_data/in_valid  source byte stream; in_last marks the final byte
//   in_ready          byte accepted when in_valid & in_ready
//   phy_active        busy indication from the downstream PHY send stage
//   tx_data/tx_enable registered byte stream to the PHY, one cycle behind input
//   underrun          one-cycle pulse when the source stalls mid-frame
//   frame_done        one-cycle pulse alongside the last FCS byte
module mac_tx_framer #(
  parameter int unsigned MIN_FRAME = 60,
  parameter int unsigned CNT_W     = 11
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  input  logic       phy_active,
  output logic [7:0] tx_data,
  output logic       tx_enable,
  output logic       underrun,
  output logic       frame_done
);

  localparam logic [31:0] CRC_POLY = 32'hEDB88320;

  if (MIN_FRAME >= (64'd1 << CNT_W)) begin : g_bad_min_frame
    $error("MIN_FRAME does not fit in the CNT_W-bit byte counter");
  end

`ifdef MAC_TX_FRAMER_PAD_EN
  typedef enum logic [2:0] {S_IDLE, S_DATA, S_PAD, S_FCS, S_WAIT} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_DATA, S_FCS, S_WAIT} state_t;
`endif

  // Reflected CRC32, one byte per call, LSB of the byte first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                             input logic [7:0]  data);
    logic [31:0] c;
    logic [7:0]  d;
    c = crc;
    d = data;
    for (int unsigned i = 0; i < 8; i++) begin
      c = (c >> 1) ^ ((c[0] ^ d[0]) ? CRC_POLY : 32'h0);
      d = d >> 1;
    end
    return c;
  endfunction

  state_t      state_q, state_d;
  logic [31:0] crc_q, crc_d;
  logic [1:0]  fcs_idx_q, fcs_idx_d;
  logic        corrupt_q, corrupt_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_enable_q, tx_enable_d;
  logic        in_ready_q, in_ready_d;
  logic        underrun_q, underrun_d;
  logic        frame_done_q, frame_done_d;

`ifdef MAC_TX_FRAMER_PAD_EN
  localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_FRAME);
  logic [CNT_W-1:0] count_q, count_d, count_inc;
  assign count_inc = (&count_q) ? count_q : count_q + 1'b1;
`endif

  logic        accept;
  logic [31:0] crc_in;
  logic [7:0]  fcs_byte;

  assign accept = in_valid & in_ready_q;
  // The first byte of a frame always starts from the all-ones seed.
  assign crc_in = crc32_byte((state_q == S_IDLE) ? 32'hFFFFFFFF : crc_q, in_data);

  always_comb begin
    state_d      = state_q;
    crc_d        = crc_q;
    fcs_idx_d    = fcs_idx_q;
    corrupt_d    = corrupt_q;
    tx_data_d    = '0;
    tx_enable_d  = 1'b0;
    underrun_d   = 1'b0;
    frame_done_d = 1'b0;
`ifdef MAC_TX_FRAMER_PAD_EN
    count_d      = count_q;
`endif

    case (fcs_idx_q)
      2'd0:    fcs_byte = crc_q[7:0];
      2'd1:    fcs_byte = crc_q[15:8];
      2'd2:    fcs_byte = crc_q[23:16];
      default: fcs_byte = crc_q[31:24];
    endcase

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          crc_d       = crc_in;
          fcs_idx_d   = '0;
          corrupt_d   = 1'b0;
          tx_data_d   = in_data;
          tx_enable_d = 1'b1;
`ifdef MAC_TX_FRAMER_PAD_EN
          count_d     = CNT_W'(1);
          if (in_last) state_d = (CNT_W'(1) < MIN_CNT) ? S_PAD : S_FCS;
          else         state_d = S_DATA;
`else
          state_d     = in_last ? S_FCS : S_DATA;
`endif
        end
      end
      S_DATA: begin
        if (accept) begin
          crc_d       = crc_in;
          tx_data_d   = in_data;
          tx_enable_d = 1'b1;
`ifdef MAC_TX_FRAMER_PAD_EN
          count_d     = count_inc;
          if (in_last) state_d = (count_inc < MIN_CNT) ? S_PAD : S_FCS;
`else
          if (in_last) state_d = S_FCS;
`endif
        end else begin
          // Source stalled: the first (corrupted) FCS byte goes out this very
          // cycle so tx_enable stays gapless; FCS then continues from byte 1.
          underrun_d  = 1'b1;
          corrupt_d   = 1'b1;
          tx_data_d   = crc_q[7:0];
          tx_enable_d = 1'b1;
          fcs_idx_d   = 2'd1;
          state_d     = S_FCS;
        end
      end
`ifdef MAC_TX_FRAMER_PAD_EN
      S_PAD: begin
        crc_d       = crc32_byte(crc_q, 8'h00);
        count_d     = count_inc;
        tx_enable_d = 1'b1;
        if (count_inc >= MIN_CNT) state_d = S_FCS;
      end
`endif
      S_FCS: begin
        tx_data_d   = corrupt_q ? fcs_byte : ~fcs_byte;
        tx_enable_d = 1'b1;
        fcs_idx_d   = fcs_idx_q + 2'd1;
        if (fcs_idx_q == 2'd3) begin
          frame_done_d = 1'b1;
          state_d      = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!phy_active) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    case (state_d)
      S_IDLE:  in_ready_d = !phy_active;
      S_DATA:  in_ready_d = 1'b1;
      default: in_ready_d = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      crc_q        <= 32'hFFFFFFFF;
      fcs_idx_q    <= '0;
      corrupt_q    <= 1'b0;
      tx_data_q    <= '0;
      tx_enable_q  <= 1'b0;
      in_ready_q   <= 1'b0;
      underrun_q   <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef MAC_TX_FRAMER_PAD_EN
      count_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      crc_q        <= crc_d;
      fcs_idx_q    <= fcs_idx_d;
      corrupt_q    <= corrupt_d;
      tx_data_q    <= tx_data_d;
      tx_enable_q  <= tx_enable_d;
      in_ready_q   <= in_ready_d;
      underrun_q   <= underrun_d;
      frame_done_q <= frame_done_d;
`ifdef MAC_TX_FRAMER_PAD_EN
      count_q      <= count_d;
`endif
    end
  end

  assign tx_data    = tx_data_q;
  assign tx_enable  = tx_enable_q;
  assign in_ready   = in_ready_q;
  assign underrun   = underrun_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_mac_tx_framer.sv
// tb_mac_tx_framer
//   Self-checking bench for mac_tx_framer. A PHY send-stage model holds
//   phy_active for 8 purge + 13 gap cycles after tx_enable drops. Expected
//   frames come from a table-driven CRC32 model. Honors MAC_TX_FRAMER_PAD_EN.
module tb_mac_tx_framer;

  localparam int MIN_FRAME = 60;
  localparam int CNT_W     = 11;
  localparam int PHY_TAIL  = 21;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       in_ready;
  logic       phy_active = 1'b0;
  logic [7:0] tx_data;
  logic       tx_enable;
  logic       underrun;
  logic       frame_done;

  always #5 clock = ~clock;

  mac_tx_framer #(.MIN_FRAME(MIN_FRAME), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .phy_active(phy_active),
    .tx_data(tx_data), .tx_enable(tx_enable), .underrun(underrun),
    .frame_done(frame_done)
  );

  // PHY send stage: active while bytes arrive, then through purge and gap.
  int phy_cnt = 0;
  always @(posedge clock) begin
    if (tx_enable) begin
      phy_active <= 1'b1;
      phy_cnt    <= PHY_TAIL;
    end else if (phy_cnt > 0) begin
      phy_cnt <= phy_cnt - 1;
      if (phy_cnt == 1) phy_active <= 1'b0;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference CRC32 (byte table, reflected polynomial, no final XOR).
  logic [31:0] crc_tab [256];
  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    return (c >> 8) ^ crc_tab[(c[7:0] ^ b)];
  endfunction

  // Monitor: collects every tx_enable run as one frame.
  logic [7:0] act_bytes[$];
  bit         act_rdy[$];
  int         fr_start[$], fr_len[$], fr_fd[$];
  int fr_closed = 0, ur_total = 0, hold_viol = 0, rise_viol = 0, fd_viol = 0;
  bit te_prev = 0, phy_prev = 0;

  always @(negedge clock) begin
    if (tx_enable) begin
      if (!te_prev) begin
        fr_start.push_back(act_bytes.size());
        fr_len.push_back(0);
        fr_fd.push_back(0);
        if (phy_prev) rise_viol++;
      end
      act_bytes.push_back(tx_data);
      act_rdy.push_back(in_ready);
      fr_len[fr_len.size()-1] = fr_len[fr_len.size()-1] + 1;
      if (frame_done) fr_fd[fr_fd.size()-1] = fr_len[fr_len.size()-1];
    end else begin
      if (te_prev) fr_closed++;
      if (frame_done) fd_viol++;
      if (phy_active && in_ready) hold_viol++;
    end
    if (underrun) ur_total++;
    te_prev  = tx_enable;
    phy_prev = phy_active;
  end

  function automatic logic [7:0] act_at(input int idx);
    return (idx >= 0 && idx < act_bytes.size()) ? act_bytes[idx] : 8'h00;
  endfunction

  // Expected model
  logic [7:0] tx_payload[$];
  logic [7:0] exp_bytes[$];
  int         exp_len[$];
  int exp_pos = 0, chk_act = 0, chk_exp = 0, closed_target = 0;

  task automatic make_payload(input int n);
    tx_payload.delete();
    for (int i = 0; i < n; i++) tx_payload.push_back(8'($urandom));
  endtask

  task automatic add_expected(input bit corrupt);
    logic [7:0]  q[$];
    logic [31:0] c, fcs;
    q = tx_payload;
`ifdef MAC_TX_FRAMER_PAD_EN
    if (!corrupt) while (q.size() < MIN_FRAME) q.push_back(8'h00);
`endif
    c = 32'hFFFFFFFF;
    foreach (q[i]) c = crc_upd(c, q[i]);
    fcs = corrupt ? c : ~c;
    for (int i = 0; i < 4; i++) q.push_back(8'(fcs >> (8 * i)));
    foreach (q[i]) exp_bytes.push_back(q[i]);
    exp_len.push_back(q.size());
  endtask

  task automatic drive_frame(input bit with_last);
    int i = 0, guard = 0, n;
    n = tx_payload.size();
    repeat ($urandom_range(0, 2)) @(negedge clock);
    while (i < n && guard < 3000) begin
      @(negedge clock);
      in_valid = 1'b1;
      in_data  = tx_payload[i];
      in_last  = with_last && (i == n - 1);
      if (in_ready) i++;
      guard++;
    end
    @(negedge clock);
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("drive_accepted", i, n);
  endtask

  task automatic wait_closed(input string tag);
    int guard = 0;
    closed_target++;
    while (fr_closed < closed_target && guard < 3000) begin
      @(negedge clock);
      guard++;
    end
    check({tag, "_closed"}, fr_closed, closed_target);
  endtask

  task automatic compare_next(input string tag);
    int s, n, la, bad, rdy1;
    if (chk_act >= fr_len.size()) begin
      check({tag, "_frames"}, fr_len.size(), chk_act + 1);
      return;
    end
    n  = exp_len[chk_exp];
    s  = fr_start[chk_act];
    la = fr_len[chk_act];
    check({tag, "_len"}, la, n);
    bad = 0;
    for (int i = 0; i < n; i++)
      if (act_at(s + i) != exp_bytes[exp_pos + i]) bad++;
    check({tag, "_bad_bytes"}, bad, 0);
    check({tag, "_done_pos"}, fr_fd[chk_act], n);
    rdy1 = 0;
    for (int i = 0; i < 4; i++)
      if (la - 1 - i >= 0 && act_rdy[s + la - 1 - i]) rdy1++;
    check({tag, "_ready_in_fcs"}, rdy1, 0);
    exp_pos += n;
    chk_act++;
    chk_exp++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ur0, full_len, s0, bad;
    logic [31:0] res;

    for (int n = 0; n < 256; n++) begin
      logic [31:0] c;
      c = 32'(n);
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      crc_tab[n] = c;
    end

    // Reset state
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_tx_data", tx_data, 0);
    check("rst_tx_enable", tx_enable, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_underrun", underrun, 0);
    check("rst_frame_done", frame_done, 0);
    reset = 1'b0;

    // Known vector "123456789"
    tx_payload.delete();
    for (int k = 0; k < 9; k++) tx_payload.push_back(8'(8'h31 + k));
    add_expected(1'b0);
    drive_frame(1'b1);
    wait_closed("vec");
`ifndef MAC_TX_FRAMER_PAD_EN
    s0 = (fr_start.size() > 0) ? fr_start[0] : 0;
    check("vec_fcs0", act_at(s0 + 9), 8'h26);
    check("vec_fcs1", act_at(s0 + 10), 8'h39);
    check("vec_fcs2", act_at(s0 + 11), 8'hF4);
    check("vec_fcs3", act_at(s0 + 12), 8'hCB);
`endif
    compare_next("vec");

`ifdef MAC_TX_FRAMER_PAD_EN
    // Short header padded to the minimum length
    make_payload(14);
    add_expected(1'b0);
    drive_frame(1'b1);
    wait_closed("pad");
    s0 = fr_start[chk_act];
    check("pad_len", fr_len[chk_act], MIN_FRAME + 4);
    bad = 0;
    for (int i = 14; i < MIN_FRAME; i++) if (act_at(s0 + i) != 8'h00) bad++;
    check("pad_zero_bytes", bad, 0);
    res = 32'hFFFFFFFF;
    for (int i = 0; i < fr_len[chk_act]; i++) res = crc_upd(res, act_at(s0 + i));
    check("pad_residue", res, 32'hDEBB20E3);
    compare_next("pad");
`endif

    // Two frames offered back to back
    make_payload($urandom_range(10, 40));
    add_expected(1'b0);
    drive_frame(1'b1);
    make_payload($urandom_range(10, 40));
    add_expected(1'b0);
    drive_frame(1'b1);
    wait_closed("b2b_a");
    wait_closed("b2b_b");
    compare_next("b2b_a");
    compare_next("b2b_b");
    check("b2b_rise_after_phy", rise_viol, 0);
    check("b2b_hold_ready", hold_viol, 0);

    // Source stalls after 20 bytes
    ur0 = ur_total;
    make_payload(20);
    add_expected(1'b1);
    drive_frame(1'b0);
    wait_closed("urun");
    check("urun_pulses", ur_total - ur0, 1);
    compare_next("urun");

    // Random frames
    for (int k = 0; k < 6; k++) begin
      make_payload($urandom_range(1, 80));
      add_expected(1'b0);
      drive_frame(1'b1);
      wait_closed("rand");
      compare_next("rand");
    end

    // Reset in the middle of a frame (PAD when padding is built in, else FCS)
    make_payload(5);
    drive_frame(1'b1);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("mid_rst_tx_enable", tx_enable, 0);
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_frame_done", frame_done, 0);
    wait_closed("mid_rst");
`ifdef MAC_TX_FRAMER_PAD_EN
    full_len = MIN_FRAME + 4;
`else
    full_len = 9;
`endif
    check("mid_rst_truncated", (chk_act < fr_len.size()) && (fr_len[chk_act] < full_len), 1);
    chk_act++;
    bad = 0;
    while (!in_ready && bad < 200) begin
      @(negedge clock);
      bad++;
    end
    check("mid_rst_ready_rise", in_ready, 1);
    check("mid_rst_ready_phy", phy_active, 0);
    make_payload(30);
    add_expected(1'b0);
    drive_frame(1'b1);
    wait_closed("post_rst");
    compare_next("post_rst");

    repeat (30) @(negedge clock);
    check("final_hold_ready", hold_viol, 0);
    check("final_rise_after_phy", rise_viol, 0);
    check("final_done_outside", fd_viol, 0);
    check("final_frame_count", fr_len.size(), exp_len.size() + 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mac_tx_framer.md
Name: mac_tx_framer

Overview:
- Sits directly upstream of the PHY preamble/gap stage and drives its data/tx_enable pair.
- Accepts an Ethernet frame byte stream (dest MAC through payload) over a valid/ready handshake.
- Pads short frames to the minimum length and appends the 4-byte CRC32 FCS.
- Holds off the next frame until the PHY stage reports it is no longer active, i.e. until purge and inter-frame gap are done.

Parameters:
- MIN_FRAME, 60: minimum bytes before FCS; shorter frames are zero-padded up to this length.
- CNT_W, 11: width of the frame byte counter; the counter saturates at 2^CNT_W-1.

Ports:
- clock  in  1  single clock for all logic
- reset  in  1  synchronous, active-high reset
- in_data  in  8  frame byte
- in_valid  in  1  in_data valid
- in_last  in  1  marks the final frame byte; qualified by in_valid
- in_ready  out  1  framer accepts in_data this cycle
- phy_active  in  1  active output of the downstream PHY send stage
- tx_data  out  8  byte to the PHY send stage
- tx_enable  out  1  frame byte valid; held high for the whole frame including FCS
- underrun  out  1  one-cycle pulse when the source stalls mid-frame
- frame_done  out  1  one-cycle pulse on the last FCS byte

Behaviour:
- Reset values: tx_data=0, tx_enable=0, in_ready=0, underrun=0, frame_done=0, state=IDLE, crc=32'hFFFFFFFF, count=0.
- Outputs are registered. Each accepted byte appears on tx_data/tx_enable the following cycle (latency 1).
- A byte is accepted when in_valid & in_ready.
- IDLE:
  - in_ready = !phy_active.
  - On an accepted byte: load crc=FFFFFFFF and update it with the byte; count=1; emit the byte.
  - If in_last is also set, go to PAD or FCS (see the length rule below). Otherwise go to DATA.
- DATA:
  - in_ready=1. Each accepted byte updates crc, increments count (saturating), and is emitted.
  - An accepted byte with in_last: go to PAD if count+1 < MIN_FRAME, else go to FCS.
  - in_valid=0 in DATA is an underrun:
    - pulse underrun;
    - emit the 4 FCS bytes as the bitwise complement of the correct FCS, so the receiver drops the frame;
    - go to FCS with the corrupt flag set;
    - skip padding.
- PAD:
  - in_ready=0. Emit 8'h00, update crc, increment count.
  - Leave for FCS on the cycle the emitted pad byte brings count to MIN_FRAME.
- FCS:
  - in_ready=0. Emit 4 bytes, LSB first: ~crc[7:0], ~crc[15:8], ~crc[23:16], ~crc[31:24]. With the corrupt flag set, emit crc bytes uncomplemented.
  - The crc register is frozen during FCS.
  - frame_done pulses together with the 4th FCS byte, then go to WAIT.
- WAIT:
  - in_ready=0, tx_enable=0.
  - Return to IDLE when phy_active==0. It is necessarily high on the first WAIT cycle.
- tx_enable is high in every cycle from the first data byte through the 4th FCS byte, with no gaps. Its cycle count equals max(len, MIN_FRAME)+4, or len+4 on underrun.
- CRC: IEEE 802.3, reflected polynomial 32'hEDB88320, processed LSB-first per byte. Single-cycle 8-bit combinational update.
- Counter saturates; there is no max-length enforcement (handled upstream).
- A frame of 1 byte with in_last in IDLE is legal and goes to PAD.
- Reset mid-frame:
  - tx_enable drops the next cycle and the state returns to IDLE.
  - A truncated frame reaches the PHY stage, which purges and gaps normally.
  - The receiver rejects it on FCS.

Optional Feature:
- Macro: MAC_TX_FRAMER_PAD_EN.
- Defined: padding as described above.
- Undefined:
  - PAD state absent; in_last goes straight to FCS whatever the length;
  - MIN_FRAME is ignored;
  - tx_enable length is len+4.

Test Plan:
- Pad undefined. Send the 9 bytes "123456789" (0x31..0x39) back-to-back with in_last on 0x39 → tx_data shows the 9 bytes, then 0x26,0x39,0xF4,0xCB. tx_enable is high 13 consecutive cycles; frame_done is on the 0xCB cycle.
- Pad defined. Send a 14-byte header with in_last → tx_enable high 64 cycles, with bytes 15..60 = 0x00. A reference CRC register (init FFFFFFFF, no final XOR) run over all 64 bytes ends at 32'hDEBB20E3.
- Two frames offered back-to-back with the PHY stage model attached → in_ready stays 0 from the first FCS byte until phy_active falls (8 purge + 13 gap cycles later). The second frame's first tx_enable cycle follows the phy_active fall by ≥1 cycle.
- Drop in_valid for 1 cycle after byte 20 of a 100-byte frame → underrun pulses once. tx_enable stays high for 20+4 cycles. The FCS bytes equal the complement of the correct FCS over those 20 bytes.
- Assert reset for 1 cycle while in PAD → tx_enable=0, in_ready=0 the next cycle, and state=IDLE. in_ready rises once phy_active=0. The next full frame's FCS is correct (crc reinitialised).
